adder_accumulator: RTL and testbench

- Sequential stage directly downstream of the 32-bit adder.
- Accepts a stream of operand beats (data plus per-beat carry-in) over a valid/ready handshake and accumulates them into a running width-bit sum.
- Counts carry-outs and beats, then presents the batch result on a valid/ready output port when the beat flagged last is accepted.
- Output is held until consumed; the block then clears and accepts the next batch.

---
 rtl/adder_accumulator.sv | 103 ++++++++++
 tb/tb_adder_accumulator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_accumulator.sv
// rtl/adder_accumulator.sv - accumulates operand beats into a batch sum with carry/beat counters
module adder_accumulator #(
  parameter int width = 32,
  parameter int cnt_w = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  input  logic             in_ci,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_sum,
  output logic [cnt_w-1:0] out_carry_cnt,
  output logic [cnt_w-1:0] out_count,
  output logic             out_sat
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [cnt_w-1:0] CNT_ONE = {{(cnt_w-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic             valid_q;
  logic [width-1:0] sum_q;
  logic [cnt_w-1:0] carry_q;
  logic [cnt_w-1:0] count_q;
  logic             sat_q;

  logic [width:0]   add_full;
  logic [width-1:0] sum_d;
  logic [cnt_w-1:0] carry_d;
  logic [cnt_w-1:0] count_d;
  logic             sat_d;
  logic             carry_out;
  logic             carry_max;
  logic             count_max;

  // Ready comes only from registered state so upstream never sees a loop through in_valid.
  assign in_ready = (state_q == ACC) && !rst;

  // Next values for one accepted beat: width+1 bit add, saturating counters, sticky saturation flag.
  always_comb begin
    add_full  = {1'b0, sum_q} + {1'b0, in_data} + (width+1)'(in_ci);
    carry_out = add_full[width];
    carry_max = &carry_q;
    count_max = &count_q;
    sum_d     = add_full[width-1:0];
    carry_d   = carry_q;
    if (carry_out && !carry_max) begin
      carry_d = carry_q + CNT_ONE;
    end
    count_d = count_max ? count_q : count_q + CNT_ONE;
    sat_d   = sat_q | (carry_out && carry_max) | count_max;
  end

  // Batch FSM: accumulate in ACC, present and hold the result in HOLD until consumed, then clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (in_valid && in_ready) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            count_q <= count_d;
            sat_q   <= sat_d;
            if (in_last) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (valid_q && out_ready) begin
            state_q <= ACC;
            valid_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign out_valid     = valid_q;
  assign out_sum       = sum_q;
  assign out_carry_cnt = carry_q;
  assign out_count     = count_q;
  assign out_sat       = sat_q;

endmodule

// File: tb/tb_adder_accumulator.sv
// tb/tb_adder_accumulator.sv - self-checking bench for adder_accumulator
module tb_adder_accumulator;

  localparam int W = 32;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_ci;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic [C-1:0] out_carry_cnt;
  logic [C-1:0] out_count;
  logic         out_sat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_accumulator #(.width(W), .cnt_w(C)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ci(in_ci), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry_cnt(out_carry_cnt), .out_count(out_count), .out_sat(out_sat)
  );

  // Offer one beat from a negedge and return at the negedge after it is accepted.
  task automatic drive_beat(input logic [W-1:0] d, input logic ci, input logic last);
    int waited;
    in_valid = 1'b1; in_data = d; in_ci = ci; in_last = last;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL beat_timeout in_ready=%b required=1", in_ready);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Called at the negedge right after the last beat was accepted: checks latency, stall stability,
  // result values, then consumes the result and checks the cleared state.
  task automatic finish_batch(input string name, input logic [W-1:0] es, input logic [C-1:0] ec,
                              input logic [C-1:0] en, input logic esat, input int stall);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_latency out_valid=%b required=1", name, out_valid); end
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== es || out_count !== en) begin
        bad++;
        $display("FAIL %s_hold valid=%b ready=%b sum=%h count=%0d required 1 0 %h %0d",
                 name, out_valid, in_ready, out_sum, out_count, es, en);
      end
    end
    total++;
    if (out_sum !== es || out_carry_cnt !== ec || out_count !== en || out_sat !== esat) begin
      bad++;
      $display("FAIL %s_result sum=%h carry=%0d count=%0d sat=%b required %h %0d %0d %b",
               name, out_sum, out_carry_cnt, out_count, out_sat, es, ec, en, esat);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_carry_cnt !== '0 || out_count !== '0 ||
        out_sat !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_clear valid=%b sum=%h carry=%0d count=%0d sat=%b ready=%b required all zero, ready=1",
               name, out_valid, out_sum, out_carry_cnt, out_count, out_sat, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = '0; in_ci = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== '0 || out_count !== '0) begin
      bad++;
      $display("FAIL reset_state ready=%b valid=%b sum=%h count=%0d required 0 0 0 0",
               in_ready, out_valid, out_sum, out_count);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release ready=%b valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive_beat(32'h5, 1'b0, 1'b0);
    drive_beat(32'hA, 1'b1, 1'b0);
    drive_beat(32'h3, 1'b0, 1'b1);
    finish_batch("basic", 32'h13, 8'd0, 8'd3, 1'b0, 0);
  endtask

  task automatic test_wrap();
    drive_beat(32'hFFFF_FFFF, 1'b1, 1'b0);
    drive_beat(32'h8000_0000, 1'b0, 1'b0);
    drive_beat(32'h8000_0000, 1'b0, 1'b1);
    finish_batch("wrap", 32'h0, 8'd2, 8'd3, 1'b0, 0);
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    drive_beat(32'h1234_5678, 1'b1, 1'b1);
    // keep offering a beat while the result is held; it must not be taken
    in_valid = 1'b1; in_data = 32'h7; in_ci = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 32'h1234_5679 || out_count !== 8'd1 ||
          out_carry_cnt !== 8'd0) begin
        bad++;
        $display("FAIL hold_stable ready=%b valid=%b sum=%h count=%0d carry=%0d required 0 1 12345679 1 0",
                 in_ready, out_valid, out_sum, out_count, out_carry_cnt);
      end
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_count !== 8'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL hold_release valid=%b count=%0d ready=%b required 0 0 1", out_valid, out_count, in_ready);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_count !== 8'd1 || out_sum !== 32'h7) begin
      bad++;
      $display("FAIL hold_next_beat count=%0d sum=%h required 1 00000007", out_count, out_sum);
    end
    drive_beat(32'h0, 1'b0, 1'b1);
    finish_batch("hold_after", 32'h7, 8'd0, 8'd2, 1'b0, 0);
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 300; i++) drive_beat(32'hFFFF_FFFF, 1'b1, (i == 300));
    finish_batch("sat", 32'h0, 8'd255, 8'd255, 1'b1, 1);
  endtask

  task automatic test_reset_mid();
    drive_beat(32'h11, 1'b0, 1'b0);
    drive_beat(32'h22, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== '0 || out_carry_cnt !== '0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL midreset_clear valid=%b sum=%h count=%0d carry=%0d ready=%b required all 0",
               out_valid, out_sum, out_count, out_carry_cnt, in_ready);
    end
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_no_result out_valid=%b required 0", out_valid); end
    end
    drive_beat(32'h1, 1'b0, 1'b0);
    drive_beat(32'h2, 1'b0, 1'b1);
    finish_batch("midreset_fresh", 32'h3, 8'd0, 8'd2, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int b = 0; b < 10; b++) begin
      int n;
      longint unsigned acc;
      int carries;
      n = $urandom_range(1, 6);
      acc = 0; carries = 0;
      for (int k = 0; k < n; k++) begin
        logic [W-1:0] d;
        logic ci;
        d  = $urandom;
        ci = $urandom_range(0, 1);
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0; in_data = $urandom; in_last = $urandom_range(0, 1);
          in_ci = $urandom_range(0, 1); out_ready = $urandom_range(0, 1);
          @(posedge clk); @(negedge clk);
        end
        out_ready = $urandom_range(0, 1);
        drive_beat(d, ci, (k == n - 1));
        acc = acc + longint'(d) + longint'(ci);
        if (acc >= 64'h1_0000_0000) begin
          carries++;
          acc = acc - 64'h1_0000_0000;
        end
      end
      finish_batch($sformatf("rand%0d", b), acc[W-1:0], C'(carries), C'(n), 1'b0, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required finish before 200000", $time);
    $fatal(1);
  end

endmodule
